gpio_input_port: RTL and testbench



---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_input_port_if.sv | 13 +
 rtl/gpio_debounce_bit.sv | 35 +++
 rtl/gpio_input_port.sv | 127 ++++++++++++
 tb/tb_gpio_input_port.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO constants: I/O addresses of the GPIO ports and the
// register offsets of the input port.
package gpio_pkg;

   // Output ports already live at 40/41; the input port follows them.
   localparam logic [8:0] GPIO_OUT0_ADDR    = 9'd40;
   localparam logic [8:0] GPIO_OUT1_ADDR    = 9'd41;
   localparam logic [8:0] GPIO_IN_BASE_ADDR = 9'd42;

   // Register offsets from the input port base address.
   typedef enum logic [1:0] {
      GPIO_IN_VALUE   = 2'd0,
      GPIO_IN_FLAGS   = 2'd1,
      GPIO_IN_RISE_EN = 2'd2,
      GPIO_IN_FALL_EN = 2'd3
   } gpio_in_reg_e;

endpackage

// File: rtl/gpio_input_port_if.sv
// CPU I/O bus slice seen by the GPIO input port.
interface gpio_input_port_if;
   logic [8:0]  AddressIO;
   logic        WriteIO;
   logic [31:0] DataOutput;
   logic [31:0] DataToMicro;
   logic        IRQ;

   modport master (output AddressIO, output WriteIO, output DataOutput,
                   input DataToMicro, input IRQ);
   modport slave  (input AddressIO, input WriteIO, input DataOutput,
                   output DataToMicro, output IRQ);
endinterface

// File: rtl/gpio_debounce_bit.sv
// One input pin: 2-FF synchronizer, tick-driven sample shifter and the
// debounced level that only moves once every sample agrees.
module gpio_debounce_bit #(
   parameter int FilterDepth = 3
) (
   input  logic CLK,
   input  logic Reset,
   input  logic tick,
   input  logic pinIn,
   output logic debounced
);

   logic [1:0]             syncFf;
   logic [FilterDepth-1:0] samples;

   // Bring the asynchronous pin into the CLK domain.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) syncFf <= '0;
      else        syncFf <= {syncFf[0], pinIn};
   end

   // Shift one synchronized sample in per prescaler tick.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)    samples <= '0;
      else if (tick) samples <= {samples[FilterDepth-2:0], syncFf[1]};
   end

   // Follow the samples only when they are unanimous; mixed history holds.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)               debounced <= 1'b0;
      else if (samples == '1)   debounced <= 1'b1;
      else if (samples == '0)   debounced <= 1'b0;
   end

endmodule

// File: rtl/gpio_input_port.sv
// GPIO input port: debounced pins, masked sticky edge flags with W1C,
// level interrupt and registered read data for the CPU I/O bus.
module gpio_input_port
   import gpio_pkg::*;
#(
   parameter int         Width       = 31,
   parameter logic [8:0] BaseAddress = GPIO_IN_BASE_ADDR,
   parameter int         DebounceDiv = 1,
   parameter int         FilterDepth = 3
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [Width-1:0]  PinsIn,
   gpio_input_port_if.slave  bus
);

   localparam int CntW = (DebounceDiv > 1) ? $clog2(DebounceDiv) : 1;

   logic [CntW-1:0]  preCnt;
   logic             tick;
   logic [Width-1:0] debounced;
   logic [Width-1:0] debPrev;
   logic [Width-1:0] riseEn;
   logic [Width-1:0] fallEn;
   logic [Width-1:0] flags;
   logic [Width-1:0] setEv;
   logic [Width-1:0] clrEv;
   logic             wrPrev;
   logic             wrStb;
   logic [8:0]       offs;
   logic             hit;
   gpio_in_reg_e     regSel;
   logic [31:0]      rdData;
   logic             unusedData;

   assign tick = (preCnt == CntW'(DebounceDiv - 1));

   // Free-running sample prescaler; wraps and ticks every DebounceDiv cycles.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)    preCnt <= '0;
      else if (tick) preCnt <= '0;
      else           preCnt <= preCnt + 1'b1;
   end

   genvar g;
   generate
      for (g = 0; g < Width; g++) begin : gBit
         gpio_debounce_bit #(.FilterDepth(FilterDepth)) uBit (
            .CLK       (CLK),
            .Reset     (Reset),
            .tick      (tick),
            .pinIn     (PinsIn[g]),
            .debounced (debounced[g])
         );
      end
   endgenerate

   // Unsigned wrap makes "offs < 4" a clean window check on the base.
   assign offs       = bus.AddressIO - BaseAddress;
   assign hit        = (offs < 9'd4);
   assign regSel     = gpio_in_reg_e'(offs[1:0]);
   assign wrStb      = bus.WriteIO & ~wrPrev & hit;
   assign unusedData = ^bus.DataOutput;

   assign setEv = (riseEn &  debounced & ~debPrev) |
                  (fallEn & ~debounced &  debPrev);

   // W1C mask, only for the single write cycle aimed at the flag register.
   always_comb begin
      clrEv = '0;
      if (wrStb && regSel == GPIO_IN_FLAGS) clrEv = bus.DataOutput[Width-1:0];
   end

   // Strobe history and previous debounced level for edge detection.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         wrPrev  <= 1'b0;
         debPrev <= '0;
      end else begin
         wrPrev  <= bus.WriteIO;
         debPrev <= debounced;
      end
   end

   // Edge enable registers, written once per WriteIO rising edge.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         riseEn <= '0;
         fallEn <= '0;
      end else if (wrStb) begin
         if (regSel == GPIO_IN_RISE_EN) riseEn <= bus.DataOutput[Width-1:0];
         if (regSel == GPIO_IN_FALL_EN) fallEn <= bus.DataOutput[Width-1:0];
      end
   end

   // Sticky flags; a set in the same cycle as a clear keeps the bit.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) flags <= '0;
      else        flags <= (flags & ~clrEv) | setEv;
   end

   // Read mux, zero-extended; undecoded addresses read 0.
   always_comb begin
      rdData = '0;
      if (hit) begin
         case (regSel)
            GPIO_IN_VALUE:   rdData = 32'(debounced);
            GPIO_IN_FLAGS:   rdData = 32'(flags);
            GPIO_IN_RISE_EN: rdData = 32'(riseEn);
            GPIO_IN_FALL_EN: rdData = 32'(fallEn);
            default:         rdData = '0;
         endcase
      end
   end

   // Registered bus outputs.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         bus.DataToMicro <= '0;
         bus.IRQ         <= 1'b0;
      end else begin
         bus.DataToMicro <= rdData;
         bus.IRQ         <= |flags;
      end
   end

endmodule

// File: tb/tb_gpio_input_port.sv
// Bench for gpio_input_port: directed scenarios plus random traffic, all
// compared cycle by cycle against a history-based behavioural model.
module tb_gpio_input_port;
   import gpio_pkg::*;

   localparam int W = 31;

   logic         CLK   = 1'b0;
   logic         Reset = 1'b0;
   logic [W-1:0] pins  = '0;
   logic [3:0]   pins2 = 4'b0010;

   gpio_input_port_if bus1();
   gpio_input_port_if bus2();

   gpio_input_port #(.Width(W)) dut1 (
      .CLK(CLK), .Reset(Reset), .PinsIn(pins), .bus(bus1));

   gpio_input_port #(.Width(4), .DebounceDiv(4)) dut2 (
      .CLK(CLK), .Reset(Reset), .PinsIn(pins2), .bus(bus2));

   always #5 CLK = ~CLK;

   int nPass   = 0;
   int nChecks = 0;

   // Model state: values as they stand after the most recent edge.
   logic [W-1:0] mDeb, mDebOld, mFlags, mRise, mFall;
   logic         mWrPrev;
   logic [W-1:0] hist[$];   // pin levels at the last six edges, oldest first

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] mRead(logic [8:0] a);
      case (a)
         9'd42:   return 32'(mDeb);
         9'd43:   return 32'(mFlags);
         9'd44:   return 32'(mRise);
         9'd45:   return 32'(mFall);
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelInit();
      mDeb = '0; mDebOld = '0; mFlags = '0; mRise = '0; mFall = '0;
      mWrPrev = 1'b0;
      hist.delete();
      for (int i = 0; i < 6; i++) hist.push_back('0);
   endtask

   // One CLK edge: advance the model with the inputs seen at the edge,
   // then compare dut1 outputs 1 ns later.
   task automatic step();
      logic [8:0]   a;
      logic         w;
      logic [31:0]  d;
      logic [W-1:0] p, setM, clrM, ones, zeros;
      logic [31:0]  expRd;
      logic         expIrq;
      a = bus1.AddressIO; w = bus1.WriteIO; d = bus1.DataOutput; p = pins;
      @(posedge CLK);
      expRd  = mRead(a);
      expIrq = |mFlags;
      // Debounced moved one edge ago -> flag this edge, using current enables.
      setM = (mRise & mDeb & ~mDebOld) | (mFall & ~mDeb & mDebOld);
      clrM = '0;
      if (w && !mWrPrev) begin
         case (a)
            9'd43: clrM  = d[W-1:0];
            9'd44: mRise = d[W-1:0];
            9'd45: mFall = d[W-1:0];
            default: ;
         endcase
      end
      mFlags  = (mFlags & ~clrM) | setM;
      mWrPrev = w;
      // Debounced after edge n follows pins at n-5..n-3 when unanimous.
      hist.push_back(p);
      hist.delete(0);
      ones    = hist[0] & hist[1] & hist[2];
      zeros   = ~(hist[0] | hist[1] | hist[2]);
      mDebOld = mDeb;
      mDeb    = (mDeb & ~zeros) | ones;
      #1;
      chk("rd",  bus1.DataToMicro, expRd);
      chk("irq", {31'd0, bus1.IRQ}, {31'd0, expIrq});
   endtask

   task automatic stepN(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr1(logic [8:0] a, logic [31:0] d);
      bus1.AddressIO = a; bus1.DataOutput = d; bus1.WriteIO = 1'b1;
      step();
      bus1.WriteIO = 1'b0;
      step();
   endtask

   task automatic doReset();
      Reset = 1'b0;
      @(posedge CLK); #1;
      chk("rst_rd",  bus1.DataToMicro, 32'd0);
      chk("rst_irq", {31'd0, bus1.IRQ}, 32'd0);
      @(posedge CLK); #1;
      Reset = 1'b1;
      modelInit();
   endtask

   logic [8:0] addrTab [7];
   int         cnt;

   initial begin
      addrTab = '{9'd40, 9'd41, 9'd42, 9'd43, 9'd44, 9'd45, 9'd60};
      bus1.AddressIO = 9'd43; bus1.WriteIO = 1'b0; bus1.DataOutput = '0;
      bus2.AddressIO = 9'd0;  bus2.WriteIO = 1'b0; bus2.DataOutput = '0;
      modelInit();
      doReset();

      // Pins all high, reset mid-debounce, then normal latency after release.
      pins = '1; bus1.AddressIO = 9'd42;
      stepN(3);
      doReset();
      stepN(5);
      step(); chk("rst_deb_c6", bus1.DataToMicro, 32'd0);
      step(); chk("rst_deb_c7", bus1.DataToMicro, 32'h7FFF_FFFF);
      bus1.AddressIO = 9'd43;
      step(); chk("rst_flags", bus1.DataToMicro, 32'd0);
      chk("rst_irq_hi", {31'd0, bus1.IRQ}, 32'd0);

      // Rising edge on pin 0 with RiseEn.
      pins = '0;
      doReset();
      stepN(10);
      wr1(9'd44, 32'h23);
      bus1.AddressIO = 9'd42;
      pins[0] = 1'b1;
      stepN(6);
      step(); chk("rise_deb", bus1.DataToMicro, 32'h1);
      chk("rise_irq_c7", {31'd0, bus1.IRQ}, 32'd0);
      step(); chk("rise_irq_c8", {31'd0, bus1.IRQ}, 32'd1);
      bus1.AddressIO = 9'd43;
      step(); chk("rise_flag", bus1.DataToMicro, 32'h1);

      // Two-cycle glitch on pin 5 must be filtered out.
      pins[5] = 1'b1; step(); step();
      pins[5] = 1'b0; stepN(10);
      bus1.AddressIO = 9'd42;
      step(); chk("glitch_deb", bus1.DataToMicro, 32'h1);
      bus1.AddressIO = 9'd43;
      step(); chk("glitch_flag", bus1.DataToMicro, 32'h1);

      // Held WriteIO: exactly one W1C; later edge re-sets bit 0.
      pins[1] = 1'b1;
      stepN(9);
      step(); chk("flags_3", bus1.DataToMicro, 32'h3);
      bus1.DataOutput = 32'h1; bus1.WriteIO = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == 10) pins[0] = 1'b0;
         if (i == 30) pins[0] = 1'b1;
         step();
         if (i == 5) chk("hold_one_wr", bus1.DataToMicro, 32'h2);
      end
      bus1.WriteIO = 1'b0;
      step(); chk("hold_reset_bit", bus1.DataToMicro, 32'h3);

      // W1C colliding with a fall-edge set on bit 0: set wins.
      wr1(9'd45, 32'h1);
      bus1.AddressIO = 9'd43; bus1.DataOutput = 32'h1;
      pins[0] = 1'b0;
      stepN(6);
      bus1.WriteIO = 1'b1; step();
      bus1.WriteIO = 1'b0; step();
      chk("collide_flags", bus1.DataToMicro, 32'h3);
      chk("collide_irq", {31'd0, bus1.IRQ}, 32'd1);
      wr1(9'd43, 32'h3);
      step();
      chk("clr_all", bus1.DataToMicro, 32'd0);
      chk("clr_irq", {31'd0, bus1.IRQ}, 32'd0);

      // Random pins, addresses and writes against the model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) pins = pins ^ W'($urandom & $urandom & $urandom);
         bus1.AddressIO = addrTab[$urandom_range(0, 6)];
         if ($urandom_range(0, 5) == 0) bus1.WriteIO = ~bus1.WriteIO;
         bus1.DataOutput = $urandom;
         step();
      end
      bus1.WriteIO = 1'b0;
      stepN(2);

      // DebounceDiv=4 instance: fall edge on pin 1.
      bus2.AddressIO = 9'd45; bus2.DataOutput = 32'h2; bus2.WriteIO = 1'b1;
      step();
      bus2.WriteIO = 1'b0;
      step();
      pins2[1] = 1'b0; bus2.AddressIO = 9'd42;
      cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus2.DataToMicro[1] == 1'b0) begin
            cnt = i;
            break;
         end
      end
      chk("div4_latency", 32'(cnt >= 12 && cnt <= 20), 32'd1);
      bus2.AddressIO = 9'd43;
      step();
      chk("div4_flag", bus2.DataToMicro, 32'h2);
      chk("div4_irq", {31'd0, bus2.IRQ}, 32'd1);
      bus2.AddressIO = 9'd60; bus1.AddressIO = 9'd60;
      step();
      chk("div4_undec", bus2.DataToMicro, 32'd0);
      chk("undec", bus1.DataToMicro, 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
